// File: rtl/key_matrix_input.sv
// 4x4 key matrix scanner with debounce and decimal entry decoder.
// Delivers signed 16-bit values to the processor through a valid/ack handshake.
module key_matrix_input #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  col_in,
  input  logic        in_ack,
  output logic [3:0]  row_sel,
  output logic [15:0] in_data,
  output logic        in_valid,
  output logic [15:0] entry,
  output logic        entry_neg,
  output logic        key_valid,
  output logic [3:0]  key_code
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE - 1);

  logic [3:0]    col_s1_q, col_s2_q;
  logic [DW-1:0] div_q;
  logic [1:0]    row_q;
  logic [15:0]   frame_q, prev_q, stable_q;
  logic [CW-1:0] match_q, match_d;
  logic          key_valid_q;
  logic [3:0]    key_code_q;
  logic [15:0]   entry_q, in_data_q;
  logic          neg_q, in_valid_q;

  logic          slot_end, frame_end, commit, key_hit;
  logic [15:0]   frame_full;
  logic [19:0]   digit_sum;

  function automatic logic [3:0] bit_index(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  always_comb begin
    slot_end   = (div_q == DIV_LAST);
    frame_end  = slot_end && (row_q == 2'd3);
    frame_full = {col_s2_q, frame_q[11:0]};
    match_d    = '0;
    if (frame_full == prev_q) begin
      match_d = (match_q == DB_LAST) ? match_q : match_q + 1'b1;
    end
    commit    = frame_end && (match_d == DB_LAST);
    // An event needs a fully released snapshot followed by exactly one key.
    key_hit   = commit && (stable_q == 16'd0) && $onehot(frame_full);
    digit_sum = {4'd0, entry_q} * 20'd10 + {16'd0, key_code_q};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_s1_q <= '0;
      col_s2_q <= '0;
      div_q    <= '0;
      row_q    <= '0;
      frame_q  <= '0;
      prev_q   <= '0;
      match_q  <= '0;
      stable_q <= '0;
    end else begin
      col_s1_q <= col_in;
      col_s2_q <= col_s1_q;
      if (slot_end) begin
        div_q                <= '0;
        row_q                <= row_q + 2'd1;
        frame_q[row_q*4 +: 4] <= col_s2_q;
      end else begin
        div_q <= div_q + 1'b1;
      end
      if (frame_end) begin
        prev_q  <= frame_full;
        match_q <= match_d;
        if (commit) stable_q <= frame_full;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      entry_q     <= '0;
      neg_q       <= 1'b0;
      in_data_q   <= '0;
      in_valid_q  <= 1'b0;
    end else begin
      key_valid_q <= key_hit;
      if (key_hit) key_code_q <= bit_index(frame_full);
      if (in_valid_q && in_ack) in_valid_q <= 1'b0;
      if (key_valid_q) begin
        case (key_code_q)
          4'd10: begin
            entry_q <= '0;
            neg_q   <= 1'b0;
          end
          4'd11: neg_q <= ~neg_q;
          4'd12: begin
            // A pending value blocks ENT entirely, even when acked this cycle.
            if (!in_valid_q) begin
              in_data_q  <= neg_q ? (~entry_q + 16'd1) : entry_q;
              in_valid_q <= 1'b1;
              entry_q    <= '0;
              neg_q      <= 1'b0;
            end
          end
          default: begin
            if (key_code_q <= 4'd9 && digit_sum <= 20'd65535) entry_q <= digit_sum[15:0];
          end
        endcase
      end
    end
  end

  assign row_sel   = 4'b0001 << row_q;
  assign in_data   = in_data_q;
  assign in_valid  = in_valid_q;
  assign entry     = entry_q;
  assign entry_neg = neg_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_key_matrix_input.sv
// Bench for key_matrix_input: keypad matrix model driving the columns, calculator-level reference model.
module tb_key_matrix_input;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  col_in;
  logic        in_ack;
  logic [3:0]  row_sel;
  logic [15:0] in_data;
  logic        in_valid;
  logic [15:0] entry;
  logic        entry_neg;
  logic        key_valid;
  logic [3:0]  key_code;

  logic [15:0] pressed;
  int checks   = 0;
  int failures = 0;

  int m_entry;
  bit m_neg;
  int m_data;
  bit m_valid;

  key_matrix_input #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clock(clock), .reset(reset), .col_in(col_in), .in_ack(in_ack),
    .row_sel(row_sel), .in_data(in_data), .in_valid(in_valid),
    .entry(entry), .entry_neg(entry_neg), .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clock = ~clock;

  // Pressed switches short the driven row onto their columns.
  always_comb begin
    col_in = 4'b0000;
    case (row_sel)
      4'b0001: col_in = pressed[3:0];
      4'b0010: col_in = pressed[7:4];
      4'b0100: col_in = pressed[11:8];
      4'b1000: col_in = pressed[15:12];
      default: col_in = 4'b0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_entry = 0; m_neg = 0; m_data = 0; m_valid = 0;
  endtask

  task automatic model_key(input int k, input bit ack);
    bit old_valid;
    old_valid = m_valid;
    if (k <= 9) begin
      if (m_entry * 10 + k <= 65535) m_entry = m_entry * 10 + k;
    end else if (k == 10) begin
      m_entry = 0; m_neg = 0;
    end else if (k == 11) begin
      m_neg = !m_neg;
    end else if (k == 12 && !old_valid) begin
      m_data  = m_neg ? (65536 - m_entry) % 65536 : m_entry;
      m_valid = 1; m_entry = 0; m_neg = 0;
    end
    if (ack && old_valid) m_valid = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".entry"}, {16'd0, entry}, m_entry);
    chk({tag, ".neg"}, {31'd0, entry_neg}, {31'd0, m_neg});
    chk({tag, ".valid"}, {31'd0, in_valid}, {31'd0, m_valid});
    chk({tag, ".data"}, {16'd0, in_data}, m_data);
  endtask

  task automatic press(input logic [15:0] mask, input int hold_clk, input int exp_events,
                       input int exp_code, input bit ack_on_evt);
    int ev = 0;
    int rel_ev = 0;
    int code = -1;
    pressed = mask;
    repeat (hold_clk) begin
      @(negedge clock);
      in_ack = 1'b0;
      if (key_valid) begin
        ev++;
        code = int'(key_code);
        if (ack_on_evt) in_ack = 1'b1;
      end
    end
    pressed = 16'd0;
    repeat (64) begin
      @(negedge clock);
      in_ack = 1'b0;
      if (key_valid) rel_ev++;
    end
    chk("events_hold", ev, exp_events);
    chk("events_release", rel_ev, 0);
    if (exp_events > 0) begin
      chk("key_code", code, exp_code);
      model_key(exp_code, ack_on_evt);
    end
    check_state("after_press");
  endtask

  task automatic press_key(input int k);
    press(16'(16'd1 << k), 64, 1, k, 1'b0);
  endtask

  task automatic do_ack();
    bit old_valid;
    @(negedge clock);
    in_ack = 1'b1;
    old_valid = m_valid;
    @(negedge clock);
    in_ack = 1'b0;
    if (old_valid) m_valid = 0;
    chk("ack.valid", {31'd0, in_valid}, {31'd0, m_valid});
    chk("ack.data", {16'd0, in_data}, m_data);
  endtask

  initial begin
    logic [3:0] exp_row;
    int k;
    reset = 1'b0; in_ack = 1'b0; pressed = 16'd0;
    model_reset();
    #12;
    chk("rst.row_sel", {28'd0, row_sel}, 32'h1);
    chk("rst.key_valid", {31'd0, key_valid}, 32'd0);
    chk("rst.key_code", {28'd0, key_code}, 32'd0);
    check_state("rst");
    @(negedge clock);
    reset = 1'b1;

    press_key(1);
    press_key(2);
    press_key(12);
    press_key(3);

    // Reset in the middle of an entry with a pending value.
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    model_reset();
    chk("midrst.row_sel", {28'd0, row_sel}, 32'h1);
    check_state("midrst");
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clock);
      if (n == 3 || n % 4 == 0) begin
        exp_row = 4'(4'd1 << ((n / 4) % 4));
        chk("rotate.row_sel", {28'd0, row_sel}, {28'd0, exp_row});
      end
    end

    press_key(1);
    chk("t2.entry1", {16'd0, entry}, 32'd1);
    press_key(2);
    chk("t2.entry12", {16'd0, entry}, 32'd12);
    press_key(12);
    chk("t2.data", {16'd0, in_data}, 32'h000C);
    do_ack();

    press_key(5);
    press_key(11);
    chk("t3.neg", {31'd0, entry_neg}, 32'd1);
    press_key(12);
    chk("t3.data", {16'd0, in_data}, 32'hFFFB);
    press_key(11);
    press_key(11);
    chk("t3.neg2", {31'd0, entry_neg}, 32'd0);
    do_ack();

    press(16'(16'd1 << 7), 16, 0, 0, 1'b0);
    press(16'h0048, 64, 0, 0, 1'b0);
    press_key(4);

    press_key(10);
    press_key(6);
    press_key(5);
    press_key(5);
    press_key(3);
    chk("t5.entry", {16'd0, entry}, 32'd6553);
    press_key(6);
    chk("t5.overflow", {16'd0, entry}, 32'd6553);
    press_key(12);
    chk("t5.data", {16'd0, in_data}, 32'd6553);

    press_key(9);
    press_key(12);
    chk("t6.data_held", {16'd0, in_data}, 32'd6553);
    chk("t6.entry_kept", {16'd0, entry}, 32'd9);
    do_ack();
    press_key(12);
    chk("t6.data", {16'd0, in_data}, 32'd9);

    // ENT coinciding with an accepting ack is ignored; the ack still lands.
    press_key(4);
    press(16'(16'd1 << 12), 64, 1, 12, 1'b1);
    chk("entack.valid", {31'd0, in_valid}, 32'd0);
    chk("entack.entry", {16'd0, entry}, 32'd4);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(2, 0) == 0) k = int'($urandom_range(15, 10));
      else k = int'($urandom_range(9, 0));
      press(16'(16'd1 << k), 64, 1, k, ($urandom_range(7, 0) == 0));
      if ($urandom_range(3, 0) == 0) do_ack();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
